// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU/loader arbiter in front of a strobe/ready memory controller.
// Define MEM_ARB_TIMEOUT_EN to enable the outstanding-transaction watchdog (tmo_err).
module mem_arbiter #(
   parameter int AW         = 24,
   parameter int PRIO_LIMIT = 4,
   parameter int TMO        = 255
) (
   input  logic          CLK20,
   input  logic          CRST,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_add,
   input  logic [7:0]    c_di,
   output logic [7:0]    c_do,
   output logic          c_ack,
   input  logic          p_req,
   input  logic          p_we,
   input  logic [AW-1:0] p_add,
   input  logic [7:0]    p_di,
   output logic [7:0]    p_do,
   output logic          p_ack,
   output logic          m_rd_n,
   output logic          m_wr_n,
   output logic [AW-1:0] m_add,
   output logic [15:0]   m_di,
   input  logic [15:0]   m_do,
   input  logic          m_rdy,
   input  logic          m_init,
   output logic          busy,
   output logic          owner,
   output logic          tmo_err
);

   localparam int CW = $clog2(PRIO_LIMIT + 1);
   localparam int TW = $clog2(TMO + 1);
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] grant_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          lat_we;
   logic          start, pick_ldr, tmo_hit, we_nx, enter_done;
   logic [7:0]    rd_byte;
   logic          unused_hi;

   assign unused_hi = ^m_do[15:8];

   // Loader wins when it is the only requester or the CPU has used up its streak.
   function automatic logic loader_wins(input logic cr, input logic pr, input logic [CW-1:0] cnt);
      return pr && (!cr || (cnt >= CW'(PRIO_LIMIT)));
   endfunction

   // Next-state decode, grant selection and watchdog expiry
   always_comb begin
      state_nx   = state;
      start      = 1'b0;
      pick_ldr   = loader_wins(c_req, p_req, grant_cnt);
      tmo_hit    = TMO_EN && ((state == ISSUE) || (state == WAIT)) && (tmo_cnt == TW'(TMO - 1));
      case (state)
         INIT: begin
            if (m_init) state_nx = IDLE;
            else        state_nx = INIT;
         end
         IDLE: begin
            if ((c_req || p_req) && m_rdy) begin
               start    = 1'b1;
               state_nx = ISSUE;
            end else begin
               state_nx = IDLE;
            end
         end
         ISSUE: begin
            if (tmo_hit)     state_nx = DONE;
            else if (!m_rdy) state_nx = WAIT;
            else             state_nx = ISSUE;
         end
         WAIT: begin
            if (tmo_hit || m_rdy) state_nx = DONE;
            else                  state_nx = WAIT;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = INIT;
      endcase
      if (start) we_nx = pick_ldr ? p_we : c_we;
      else       we_nx = lat_we;
      enter_done = (state_nx == DONE) && (state != DONE);
      rd_byte    = tmo_hit ? 8'hFF : m_do[7:0];
   end

   // State register, request latch, fairness streak and watchdog counter
   always_ff @(posedge CLK20 or negedge CRST) begin
      if (!CRST) begin
         state     <= INIT;
         owner     <= 1'b0;
         lat_we    <= 1'b0;
         m_add     <= '0;
         m_di      <= 16'hFF00;
         grant_cnt <= '0;
         tmo_cnt   <= '0;
      end else begin
         state <= state_nx;
         if (start) begin
            owner     <= pick_ldr;
            lat_we    <= we_nx;
            m_add     <= pick_ldr ? p_add : c_add;
            m_di      <= {8'hFF, (pick_ldr ? p_di : c_di)};
            grant_cnt <= (pick_ldr || !p_req) ? '0 : grant_cnt + CW'(1);
            tmo_cnt   <= '0;
         end else if ((state == ISSUE) || (state == WAIT)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end
      end
   end

   // Strobes are low exactly while in ISSUE; busy covers ISSUE..DONE
   always_ff @(posedge CLK20 or negedge CRST) begin
      if (!CRST) begin
         m_rd_n <= 1'b1;
         m_wr_n <= 1'b1;
         busy   <= 1'b0;
      end else begin
         m_rd_n <= !((state_nx == ISSUE) && !we_nx);
         m_wr_n <= !((state_nx == ISSUE) && we_nx);
         busy   <= (state_nx == ISSUE) || (state_nx == WAIT) || (state_nx == DONE);
      end
   end

   // Completion: one-cycle ack and read data routed only to the owner
   always_ff @(posedge CLK20 or negedge CRST) begin
      if (!CRST) begin
         c_ack <= 1'b0;
         p_ack <= 1'b0;
         c_do  <= 8'hFF;
         p_do  <= 8'hFF;
      end else begin
         c_ack <= enter_done && !owner;
         p_ack <= enter_done && owner;
         if (enter_done && !lat_we) begin
            if (owner) p_do <= rd_byte;
            else       c_do <= rd_byte;
         end
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   logic tmo_err_r;

   // Sticky watchdog flag, cleared only by reset
   always_ff @(posedge CLK20 or negedge CRST) begin
      if (!CRST)        tmo_err_r <= 1'b0;
      else if (tmo_hit) tmo_err_r <= 1'b1;
   end

   assign tmo_err = tmo_err_r;
`else
   assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-timeline model plus reactive memory controller.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int AW = 24;
   localparam int PL = 4;
   localparam int TMO = 255;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic CLK20 = 1'b0;
   logic CRST = 1'b0;
   logic c_req, c_we, c_ack, p_req, p_we, p_ack;
   logic [AW-1:0] c_add, p_add, m_add;
   logic [7:0] c_di, c_do, p_di, p_do;
   logic m_rd_n, m_wr_n, m_rdy, m_init, busy, owner, tmo_err;
   logic [15:0] m_di, m_do;

   mem_arbiter #(.AW(AW), .PRIO_LIMIT(PL), .TMO(TMO)) dut (
      .CLK20(CLK20), .CRST(CRST),
      .c_req(c_req), .c_we(c_we), .c_add(c_add), .c_di(c_di), .c_do(c_do), .c_ack(c_ack),
      .p_req(p_req), .p_we(p_we), .p_add(p_add), .p_di(p_di), .p_do(p_do), .p_ack(p_ack),
      .m_rd_n(m_rd_n), .m_wr_n(m_wr_n), .m_add(m_add), .m_di(m_di),
      .m_do(m_do), .m_rdy(m_rdy), .m_init(m_init),
      .busy(busy), .owner(owner), .tmo_err(tmo_err)
   );

   always #25 CLK20 = ~CLK20;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge CLK20) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // model state
   logic [7:0] mem [16];
   bit run = 0, active = 0, inited = 0, tmo_path = 0;
   int idle_at = 0, t0 = 0, d1 = 0, d2 = 0, ack_at = 0, str_end = 0, cnt = 0;
   bit mdl_own = 0, mdl_we = 0;
   logic [AW-1:0] mdl_ad = '0;
   logic [7:0] mdl_dat = 8'h00;
   logic [AW-1:0] e_add = '0;
   logic [15:0] e_di = 16'hFF00;
   logic e_owner = 1'b0, e_tmo = 1'b0;
   logic [7:0] e_cdo = 8'hFF, e_pdo = 8'hFF;
   bit grant_log[$];
   int c_acks = 0, p_acks = 0, first_str = -1, last_ack = -1;
   logic [AW-1:0] snap_add;
   logic [15:0] snap_di;
   logic snap_rd, snap_wr;

   // stimulus control
   int mode = 0;
   bit fast = 1, stuck = 0, want_rst = 0, rst_hit = 0, c_oneshot = 0, p_oneshot = 0;
   logic init_v = 1'b0;
   logic h_creq = 0, h_cwe = 0, h_preq = 0, h_pwe = 0;
   logic [AW-1:0] h_cadd = '0, h_padd = '0;
   logic [7:0] h_cdi = 8'h00, h_pdi = 8'h00;
   bit exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   int c;
   bit ack_now, in_str, ldr;
   logic [7:0] rd;

   always @(negedge CLK20) begin
      if (run) begin
         c = cyc;
         if (active && c == t0) begin
            e_owner = mdl_own;
            e_add = mdl_ad;
            e_di = {8'hFF, mdl_dat};
         end
         ack_now = active && (c == ack_at);
         if (ack_now) begin
            if (!mdl_we) begin
               rd = tmo_path ? 8'hFF : mem[mdl_ad[3:0]];
               if (mdl_own) e_pdo = rd;
               else e_cdo = rd;
            end else if (!tmo_path) begin
               mem[mdl_ad[3:0]] = mdl_dat;
            end
            if (tmo_path) e_tmo = 1'b1;
         end
         in_str = active && (c >= t0) && (c <= str_end);
         chk("strobe_exclusive", m_rd_n | m_wr_n, 1);
         chk("m_rd_n", m_rd_n, !(in_str && !mdl_we));
         chk("m_wr_n", m_wr_n, !(in_str && mdl_we));
         chk("busy", busy, active && (c >= t0) && (c <= ack_at));
         chk("c_ack", c_ack, ack_now && !mdl_own);
         chk("p_ack", p_ack, ack_now && mdl_own);
         chk("owner", owner, e_owner);
         chk("m_add", m_add, e_add);
         chk("m_di", m_di, e_di);
         chk("c_do", c_do, e_cdo);
         chk("p_do", p_do, e_pdo);
         chk("tmo_err", tmo_err, e_tmo);
         if ((!m_rd_n || !m_wr_n) && first_str < 0) first_str = c;
         if (c_ack) begin c_acks++; last_ack = c; end
         if (p_ack) p_acks++;
         if (active && c == t0) begin
            snap_add = m_add; snap_di = m_di; snap_rd = m_rd_n; snap_wr = m_wr_n;
         end
         if (ack_now) begin
            active = 0;
            idle_at = c + 1;
            if (mdl_own && p_oneshot) h_preq = 1'b0;
            if (!mdl_own && c_oneshot) h_creq = 1'b0;
         end
         if (want_rst && active && c > str_end && c < ack_at) begin
            CRST = 1'b0;
            run = 0;
            rst_hit = 1;
         end else begin
            if (mode == 1) begin
               c_req = ($urandom_range(0, 2) != 0); c_we = 1'($urandom);
               c_add = AW'($urandom); c_di = 8'($urandom);
               p_req = ($urandom_range(0, 2) != 0); p_we = 1'($urandom);
               p_add = AW'($urandom); p_di = 8'($urandom);
            end else begin
               c_req = h_creq; c_we = h_cwe; c_add = h_cadd; c_di = h_cdi;
               p_req = h_preq; p_we = h_pwe; p_add = h_padd; p_di = h_pdi;
            end
            m_init = init_v;
            if (active) m_rdy = !((c >= t0 + d1) && (c <= t0 + d1 + d2));
            else m_rdy = (mode == 1) ? ($urandom_range(0, 7) != 0) : 1'b1;
            if (active && c == t0 + d1 + d2 + 1) m_do = {8'hFF, mem[mdl_ad[3:0]]};
            else m_do = 16'($urandom);
            if (!inited && m_init) begin inited = 1; idle_at = c + 1; end
            if (inited && !active && c >= idle_at && (c_req || p_req) && m_rdy) begin
               ldr = p_req && (!c_req || cnt >= PL);
               if (ldr || !p_req) cnt = 0;
               else cnt = cnt + 1;
               mdl_own = ldr;
               mdl_we = ldr ? p_we : c_we;
               mdl_ad = ldr ? p_add : c_add;
               mdl_dat = ldr ? p_di : c_di;
               t0 = c + 1;
               if (stuck) begin d1 = 100000; d2 = 0; end
               else if (fast) begin d1 = 0; d2 = 0; end
               else begin d1 = $urandom_range(0, 3); d2 = $urandom_range(0, 3); end
               if (TMO_ON && (d1 + d2 + 2 >= TMO)) begin
                  tmo_path = 1;
                  ack_at = t0 + TMO;
                  str_end = (d1 < TMO) ? t0 + d1 : t0 + TMO - 1;
               end else begin
                  tmo_path = 0;
                  ack_at = t0 + d1 + d2 + 2;
                  str_end = t0 + d1;
               end
               active = 1;
               grant_log.push_back(ldr);
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_m_rd_n"}, m_rd_n, 1);
      chk({tag, "_m_wr_n"}, m_wr_n, 1);
      chk({tag, "_c_ack"}, c_ack, 0);
      chk({tag, "_p_ack"}, p_ack, 0);
      chk({tag, "_c_do"}, c_do, 8'hFF);
      chk({tag, "_p_do"}, p_do, 8'hFF);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_owner"}, owner, 0);
      chk({tag, "_tmo_err"}, tmo_err, 0);
      chk({tag, "_m_add"}, m_add, 0);
      chk({tag, "_m_di"}, m_di, 16'hFF00);
   endtask

   int n, base;

   initial begin
      c_req = 0; c_we = 0; c_add = '0; c_di = 8'h00;
      p_req = 0; p_we = 0; p_add = '0; p_di = 8'h00;
      m_rdy = 1'b1; m_init = 1'b0; m_do = 16'h0000;
      for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17 + 3);
      mem[0] = 8'h3C;
      CRST = 1'b0;
      repeat (3) @(negedge CLK20);
      check_reset("reset");
      @(negedge CLK20) CRST = 1'b1;
      @(posedge CLK20);

      // CPU read of 0x00F800 held off by 10 cycles of m_init low
      mode = 0; fast = 1; init_v = 1'b0;
      h_creq = 1'b1; h_cwe = 1'b0; h_cadd = 24'h00F800; c_oneshot = 1;
      run = 1;
      repeat (10) @(posedge CLK20);
      init_v = 1'b1;
      n = 0;
      while (c_acks < 1 && n < 300) begin @(posedge CLK20); n++; end
      repeat (5) @(posedge CLK20);
      chk("init_c_ack_count", c_acks, 1);
      chk("init_p_ack_count", p_acks, 0);
      chk("init_first_grant_cpu", grant_log.size() > 0 ? grant_log[0] : 1'b1, 0);
      chk("init_strobe_after_m_init", first_str, idle_at - 4 + 1);
      chk("cpu_read_c_do", c_do, 8'h3C);
      chk("min_latency", last_ack - first_str, 2);

      // loader write 0x01F800 <- A5
      h_preq = 1'b1; h_pwe = 1'b1; h_padd = 24'h01F800; h_pdi = 8'hA5; p_oneshot = 1;
      n = 0;
      while (p_acks < 1 && n < 300) begin @(posedge CLK20); n++; end
      repeat (5) @(posedge CLK20);
      chk("ldr_p_ack_count", p_acks, 1);
      chk("ldr_c_ack_unchanged", c_acks, 1);
      chk("ldr_m_add", snap_add, 24'h01F800);
      chk("ldr_m_di", snap_di, 16'hFFA5);
      chk("ldr_m_wr_n", snap_wr, 0);
      chk("ldr_m_rd_n", snap_rd, 1);
      chk("ldr_mem_written", mem[0], 8'hA5);

      // both requesters held: fairness pattern
      fast = 0; c_oneshot = 0; p_oneshot = 0;
      h_cwe = 1'b0; h_pwe = 1'b0; h_cadd = 24'h000005; h_padd = 24'h00000A;
      base = grant_log.size();
      h_creq = 1'b1; h_preq = 1'b1;
      n = 0;
      while (grant_log.size() < base + 10 && n < 1000) begin @(posedge CLK20); n++; end
      h_creq = 1'b0; h_preq = 1'b0;
      chk("fair_grant_count", (grant_log.size() >= base + 10) ? 1 : 0, 1);
      for (int i = 0; i < 10; i++)
         chk($sformatf("fair_grant_%0d", i), (grant_log.size() > base + i) ? grant_log[base + i] : 1'bx, exp_seq[i]);
      repeat (20) @(posedge CLK20);

      // randomized traffic
      mode = 1;
      repeat (3000) @(posedge CLK20);

`ifdef MEM_ARB_TIMEOUT_EN
      mode = 0;
      repeat (20) @(posedge CLK20);
      n = c_acks;
      stuck = 1; c_oneshot = 1; h_cwe = 1'b0; h_creq = 1'b1;
      base = 0;
      while (c_acks == n && base < 600) begin @(posedge CLK20); base++; end
      chk("tmo_ack_seen", c_acks, n + 1);
      chk("tmo_latency", last_ack - t0, 255);
      chk("tmo_c_do", c_do, 8'hFF);
      chk("tmo_err_set", tmo_err, 1);
      stuck = 0;
      repeat (5) @(posedge CLK20);
      mode = 1;
`endif

      // reset asserted while a transaction waits for the controller
      n = c_acks + p_acks;
      want_rst = 1;
      base = 0;
      while (!rst_hit && base < 3000) begin @(posedge CLK20); base++; end
      chk("rst_in_wait_reached", rst_hit, 1);
      #1;
      check_reset("midrst");
      c_req = 1'b1; p_req = 1'b0; m_init = 1'b0; m_rdy = 1'b1;
      repeat (2) @(posedge CLK20);
      @(negedge CLK20) CRST = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK20);
         chk("post_rst_m_rd_n", m_rd_n, 1);
         chk("post_rst_ack", c_ack | p_ack, 0);
      end
      chk("rst_no_ack", c_acks + p_acks, n);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
